// File: rtl/demux1to4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one input stream in,
// four registered output channels out.
interface demux1to4_stream_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [1:0]    sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*DW-1:0] out_data;
    logic [3:0]    out_last;

    modport master (
        output in_valid, in_data, in_last, sel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, sel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/demux1to4_stream.sv
// 1-to-4 packet-locked stream demux with a 1-entry register per channel.
// Optional per-channel packet counters are built when DEMUX_CNT_EN is defined.
module demux1to4_stream #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    demux1to4_stream_if.slave s,
    output logic            busy,
    output logic [4*CW-1:0] pkt_cnt
);
    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         ch;
    logic [1:0]         target;
    logic               acc;
    logic [3:0]         vld;
    logic [3:0]         lst;
    logic [3:0][DW-1:0] dat;

    // sel only matters on the first beat; afterwards the locked route wins
    assign target     = (state == ROUTE) ? ch : s.sel;
    assign s.in_ready = ~vld[target] | s.out_ready[target];
    assign acc        = s.in_valid & s.in_ready;

    assign s.out_valid = vld;
    assign s.out_last  = lst;
    assign s.out_data  = dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= 2'd0;
            busy  <= 1'b0;
        end else if (acc) begin
            unique case (state)
                IDLE: begin
                    ch <= s.sel;
                    if (!s.in_last) begin
                        state <= ROUTE;
                        busy  <= 1'b1;
                    end
                end
                ROUTE: begin
                    if (s.in_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // load takes priority over drain so a channel sustains 1 beat/clk
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            lst <= '0;
            dat <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && target == 2'(i)) begin
                    vld[i] <= 1'b1;
                    lst[i] <= s.in_last;
                    dat[i] <= s.in_data;
                end else if (s.out_ready[i]) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [3:0][CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vld[i] && s.out_ready[i] && lst[i])
                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    assign pkt_cnt = cnt;
`else
    assign pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream: routing, packet lock,
// backpressure, mid-packet reset and packet counters.
module tb_demux1to4_stream;
    localparam int DW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [4*CW-1:0] pkt_cnt;

    int total = 0;
    int bad   = 0;

    demux1to4_stream_if #(.DW(DW)) bus ();

    demux1to4_stream #(.DW(DW), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (bus),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] chd(input int i);
        return bus.out_data[i*DW +: DW];
    endfunction

    task automatic beat(input logic [1:0] s, input logic [7:0] d,
                        input logic l);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    logic [CW-1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.in_last   = 1'b0;
        bus.sel       = 2'd0;
        bus.out_ready = 4'h0;

        // reset held with in_valid high
        tick();
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_data", 64'(bus.out_data), 64'h0);
        chk("rst_last", 64'(bus.out_last), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cnt", 64'(pkt_cnt), 64'h0);
        chk("rst_ready", 64'(bus.in_ready), 64'h1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        // single-beat routing
        bus.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            beat(2'(k), 8'hA0 + 8'(k), 1'b1);
            tick();
            chk($sformatf("sb%0d_valid", k), 64'(bus.out_valid),
                64'(4'b0001 << k));
            chk($sformatf("sb%0d_data", k), 64'(chd(k)),
                64'(8'hA0 + 8'(k)));
            chk($sformatf("sb%0d_last", k), 64'(bus.out_last[k]), 64'h1);
            chk($sformatf("sb%0d_busy", k), 64'(busy), 64'h0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sb_drained", 64'(bus.out_valid), 64'h0);

        // packet lock: sel changes mid-packet
        beat(2'd2, 8'h11, 1'b0);
        tick();
        chk("pl1_valid", 64'(bus.out_valid), 64'h4);
        chk("pl1_data", 64'(chd(2)), 64'h11);
        chk("pl1_busy", 64'(busy), 64'h1);
        beat(2'd1, 8'h22, 1'b0);
        tick();
        chk("pl2_valid", 64'(bus.out_valid), 64'h4);
        chk("pl2_data", 64'(chd(2)), 64'h22);
        chk("pl2_busy", 64'(busy), 64'h1);
        beat(2'd1, 8'h33, 1'b1);
        tick();
        chk("pl3_valid", 64'(bus.out_valid), 64'h4);
        chk("pl3_data", 64'(chd(2)), 64'h33);
        chk("pl3_last", 64'(bus.out_last[2]), 64'h1);
        chk("pl3_busy", 64'(busy), 64'h0);
        beat(2'd1, 8'h44, 1'b1);
        tick();
        chk("pl_next_valid", 64'(bus.out_valid), 64'h2);
        chk("pl_next_data", 64'(chd(1)), 64'h44);
        bus.in_valid = 1'b0;
        tick();

        // backpressure on ch1, independent ch3 drain
        bus.out_ready = 4'h0;
        beat(2'd3, 8'h77, 1'b1);
        tick();
        chk("bp_ch3_load", 64'(bus.out_valid), 64'h8);
        beat(2'd1, 8'h55, 1'b0);
        tick();
        chk("bp_b1_valid", 64'(bus.out_valid), 64'hA);
        chk("bp_b1_busy", 64'(busy), 64'h1);
        beat(2'd0, 8'h66, 1'b1);
        #1;
        chk("bp_stall_ready", 64'(bus.in_ready), 64'h0);
        tick();
        chk("bp_hold_data", 64'(chd(1)), 64'h55);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'hA);
        bus.out_ready = 4'h8;
        #1;
        chk("bp_still_stall", 64'(bus.in_ready), 64'h0);
        tick();
        chk("bp_ch3_drain", 64'(bus.out_valid), 64'h2);
        chk("bp_ch3_keep", 64'(chd(3)), 64'h77);
        chk("bp_ch1_keep", 64'(chd(1)), 64'h55);
        bus.out_ready = 4'h2;
        #1;
        chk("bp_release", 64'(bus.in_ready), 64'h1);
        tick();
        chk("bp_b2_valid", 64'(bus.out_valid), 64'h2);
        chk("bp_b2_data", 64'(chd(1)), 64'h66);
        chk("bp_b2_last", 64'(bus.out_last[1]), 64'h1);
        chk("bp_b2_busy", 64'(busy), 64'h0);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(bus.out_valid), 64'h0);

        // reset after beat 1 of a 4-beat packet
        bus.out_ready = 4'h0;
        beat(2'd0, 8'h10, 1'b0);
        tick();
        chk("mr_busy", 64'(busy), 64'h1);
        chk("mr_valid", 64'(bus.out_valid), 64'h1);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        chk("mr_rst_busy", 64'(busy), 64'h0);
        chk("mr_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("mr_rst_data", 64'(bus.out_data), 64'h0);
        rst = 1'b0;
        beat(2'd3, 8'h99, 1'b1);
        tick();
        chk("mr_next_valid", 64'(bus.out_valid), 64'h8);
        chk("mr_next_data", 64'(chd(3)), 64'h99);
        chk("mr_next_busy", 64'(busy), 64'h0);
        bus.in_valid = 1'b0;

        // packet counters, from a clean reset
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.out_ready = 4'hF;
        for (int p = 0; p < 5; p++) begin
            beat(2'd0, 8'(p), 1'b1);
            tick();
            bus.in_valid = 1'b0;
            tick();
`ifdef DEMUX_CNT_EN
            chk($sformatf("cnt%0d", p), 64'(pkt_cnt),
                64'({6'b0, cnt_exp[p]}));
`else
            chk($sformatf("cnt%0d", p), 64'(pkt_cnt), 64'h0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
